// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-master main-memory arbiter.
// Owner encoding of the registered read-return tag and the default address width.
package mem_arbiter_pkg;

  localparam int unsigned ADDR_W_DEF = 14;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_P0   = 2'd1,
    OWN_P1   = 2'd2
  } owner_e;

endpackage

// File: rtl/mem_arbiter_starve_cnt.sv
// Starvation guard for port 1: counts refused request cycles, saturates at MAX_WAIT
// and raises starve so the arbiter forces one port-1 grant.
module arb_starve_cnt #(
  parameter int unsigned MAX_WAIT = 8,
  parameter int unsigned CNT_W    = 8
) (
  input  logic clk,
  input  logic rstn,
  input  logic m1_req,
  input  logic m1_gnt,
  output logic starve
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);

  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!m1_req || m1_gnt)
      wait_cnt_d = '0;
    else if (wait_cnt_q != MAX_CNT)
      wait_cnt_d = wait_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rstn)
      wait_cnt_q <= '0;
    else
      wait_cnt_q <= wait_cnt_d;
  end

  assign starve = (wait_cnt_q == MAX_CNT);

endmodule

// File: rtl/mem_arbiter.sv
// Two-master arbiter for the single-port main memory: CPU priority with starvation
// guard and port-1 burst lock. MEM_ARBITER_ROUND_ROBIN_EN selects alternating priority.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned MAX_WAIT = 8,
  parameter int unsigned CNT_W    = 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [3:0]        m0_wmask,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [31:0]       m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [31:0]       m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [3:0]        m1_wmask,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [31:0]       m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [31:0]       m1_rdata,
  input  logic              m1_lock,
  output logic              mem_wren,
  output logic [3:0]        mem_wmask,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  logic   grant_p0, grant_p1;
  logic   lock_q, lock_d;
  owner_e owner_q, owner_d;

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
  // last_q high means port 1 was granted most recently; reset value lets port 0 win first
  logic last_q, last_d;

  always_comb begin
    last_d = last_q;
    if (grant_p0) last_d = 1'b0;
    if (grant_p1) last_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rstn) last_q <= 1'b1;
    else       last_q <= last_d;
  end
`else
  logic starve;

  arb_starve_cnt #(
    .MAX_WAIT (MAX_WAIT),
    .CNT_W    (CNT_W)
  ) u_starve (
    .clk    (clk),
    .rstn   (rstn),
    .m1_req (m1_req),
    .m1_gnt (grant_p1),
    .starve (starve)
  );
`endif

  always_comb begin
    grant_p0 = 1'b0;
    grant_p1 = 1'b0;
    if (rstn) begin
      if (lock_q && m1_req)
        grant_p1 = 1'b1;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
      else if (m0_req && m1_req) begin
        if (last_q) grant_p0 = 1'b1;
        else        grant_p1 = 1'b1;
      end
`else
      else if (starve && m1_req)
        grant_p1 = 1'b1;
`endif
      else if (m0_req)
        grant_p0 = 1'b1;
      else if (m1_req)
        grant_p1 = 1'b1;
    end
  end

  // Idle cycles leave mem_addr on the CPU address so the CPU path sees no extra mux level
  always_comb begin
    mem_wren  = 1'b0;
    mem_wmask = '0;
    mem_addr  = m0_addr;
    mem_wdata = '0;
    if (grant_p0) begin
      mem_wren  = m0_we;
      mem_wmask = m0_we ? m0_wmask : 4'b0000;
      mem_wdata = m0_wdata;
    end else if (grant_p1) begin
      mem_wren  = m1_we;
      mem_wmask = m1_we ? m1_wmask : 4'b0000;
      mem_addr  = m1_addr;
      mem_wdata = m1_wdata;
    end
  end

  always_comb begin
    lock_d = lock_q;
    if (grant_p1 && m1_lock)  lock_d = 1'b1;
    if (!m1_lock || !m1_req)  lock_d = 1'b0;

    owner_d = OWN_NONE;
    if (grant_p0 && !m0_we)      owner_d = OWN_P0;
    else if (grant_p1 && !m1_we) owner_d = OWN_P1;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      lock_q  <= 1'b0;
      owner_q <= OWN_NONE;
    end else begin
      lock_q  <= lock_d;
      owner_q <= owner_d;
    end
  end

  assign m0_gnt    = grant_p0;
  assign m1_gnt    = grant_p1;
  // Gating with rstn drops the return of a read accepted just before reset
  assign m0_rvalid = rstn && (owner_q == OWN_P0);
  assign m1_rvalid = rstn && (owner_q == OWN_P1);
  assign m0_rdata  = mem_rdata;
  assign m1_rdata  = mem_rdata;

endmodule
